// File: rtl/reg_arb_pkg.sv
// Shared types, default sizes and the round-robin search used by the
// register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int DW_DEF   = 8;
  localparam int MAXREQ   = 8;

  // First set bit of req at or above ptr, wrapping modulo n (n <= MAXREQ).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                         input logic [MAXREQ-1:0] req,
                                         input int n);
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx]) begin
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: winner index searching up from ptr.
module reg_arb_rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any_req
);

  logic [MAXREQ-1:0] req_pad;
  logic [2:0]        pick;

  // Pad to the package search width and take the first requester from ptr.
  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = req;
    pick                = rr_next(3'(ptr), req_pad, NREQ);
    win                 = pick[PW-1:0];
    any_req             = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving the load enables and data bus of a
// shared register bank. Optional macro REG_ARB_LOCK_EN adds a per-requester
// lock input that keeps the grant for back-to-back writes.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, win_q, pick;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            any_req;
  logic            ld_pick, ld_again, adv_ptr, addr_ok;
  logic [NREQ-1:0] gnt_d, ack_d;
  logic [NREG-1:0] en_d;

  reg_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (pick),
    .any_req (any_req)
  );

  assign addr_ok = int'(addr_q) < NREG;

  // Next state plus the latch/pointer controls that go with each transition.
  always_comb begin
    state_d  = state_q;
    ld_pick  = 1'b0;
    ld_again = 1'b0;
    adv_ptr  = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = WRITE;
        ld_pick = 1'b1;
      end
      WRITE: state_d = ACK;
      ACK: begin
        state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
        if (lock[win_q]) begin
          if (req[win_q]) begin
            state_d  = WRITE;
            ld_again = 1'b1;
          end
        end else begin
          adv_ptr = 1'b1;
        end
`else
        adv_ptr = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pointer and the latched winner, address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      win_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (ld_pick) begin
        win_q  <= pick;
        addr_q <= addr[pick*AW +: AW];
        data_q <= wdata[pick*DW +: DW];
      end else if (ld_again) begin
        addr_q <= addr[win_q*AW +: AW];
        data_q <= wdata[win_q*DW +: DW];
      end
      if (adv_ptr)
        ptr_q <= (int'(win_q) == NREQ-1) ? '0 : win_q + PW'(1);
    end
  end

  // One-hot decode of the current state into next-cycle output values.
  always_comb begin
    gnt_d = '0;
    ack_d = '0;
    en_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_d[i] = (state_q != IDLE) && (int'(win_q) == i);
      ack_d[i] = (state_q == ACK)  && (int'(win_q) == i);
    end
    for (int r = 0; r < NREG; r++)
      en_d[r] = (state_q == WRITE) && (int'(addr_q) == r);
  end

  // Registered outputs; reg_d keeps the last written value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      ack    <= '0;
      err    <= 1'b0;
      reg_en <= '0;
      reg_d  <= '0;
      busy   <= 1'b0;
    end else begin
      gnt    <= gnt_d;
      ack    <= ack_d;
      err    <= (state_q == ACK) && !addr_ok;
      reg_en <= en_d;
      busy   <= state_q != IDLE;
      if (state_q == WRITE) reg_d <= data_q;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (4 requesters, 8 registers, 4-bit
// addresses so that out-of-range targets can be presented).
module tb_reg_write_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int DW   = 8;
  localparam int AW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, ack;
  logic               err, busy;
  logic [NREG-1:0]    reg_en;
  logic [DW-1:0]      reg_d;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0]    lock = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef REG_ARB_LOCK_EN
    .lock   (lock),
`endif
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .err    (err),
    .reg_en (reg_en),
    .reg_d  (reg_d),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int j = 0; j < NREQ; j++) if (v[j]) r = j;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, k, any_ack;
    req = '0; addr = '0; wdata = '0; rst = 1'b0;
    #2;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_en",  32'(reg_en), 0);
    chk("rst_d",   32'(reg_d), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single request from requester 1 to register 3
    req = 4'b0010; addr[1*AW +: AW] = 4'd3; wdata[1*DW +: DW] = 8'hA5;
    tick();
    chk("s_lat_gnt", 32'(gnt), 0);
    tick();
    req = '0;
    chk("s_gnt",  32'(gnt), 32'b0010);
    chk("s_en",   32'(reg_en), 32'h08);
    chk("s_d",    32'(reg_d), 32'hA5);
    chk("s_busy", 32'(busy), 1);
    chk("s_ack0", 32'(ack), 0);
    tick();
    chk("s_ack",  32'(ack), 32'b0010);
    chk("s_en_off", 32'(reg_en), 0);
    chk("s_err",  32'(err), 0);
    tick();
    chk("s_idle_busy", 32'(busy), 0);
    chk("s_idle_gnt",  32'(gnt), 0);
    chk("s_hold_d",    32'(reg_d), 32'hA5);

    // All four requesting continuously from reset
    rst = 1'b1; tick(); tick();
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]  = AW'(i);
      wdata[i*DW +: DW] = DW'(8'h10 + i);
    end
    rst = 1'b0; req = 4'b1111;
    last = 0; k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      tick();
      if (ack != 0) begin
        if (k > 0) chk("rr_gap", 32'(c - last), 3);
        chk("rr_order", 32'(idx_of(ack)), 32'(k % 4));
        last = c;
        k++;
        if (k == 5) req = '0;
      end
    end
    chk("rr_count", 32'(k), 5);
    tick(); tick();

    // Requester 2 drops req and changes data while in WRITE
    do_reset();
    req = 4'b0100; addr[2*AW +: AW] = 4'd5; wdata[2*DW +: DW] = 8'h3C;
    tick();
    req = '0; wdata[2*DW +: DW] = 8'hFF; addr[2*AW +: AW] = 4'd1;
    tick();
    chk("drop_d",  32'(reg_d), 32'h3C);
    chk("drop_en", 32'(reg_en), 32'h20);
    tick();
    chk("drop_ack", 32'(ack), 32'b0100);
    tick();

    // Out-of-range address: no enable, err with ack
    req = 4'b0001; addr[0*AW +: AW] = 4'd9; wdata[0*DW +: DW] = 8'h77;
    tick();
    tick();
    req = '0;
    chk("oor_gnt", 32'(gnt), 32'b0001);
    chk("oor_en",  32'(reg_en), 0);
    tick();
    chk("oor_ack", 32'(ack), 32'b0001);
    chk("oor_err", 32'(err), 1);
    tick();
    chk("oor_err_off", 32'(err), 0);

    // Reset while in WRITE (pointer is 1 here before the abort)
    req = 4'b0010;
    tick();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("abort_gnt",  32'(gnt), 0);
    chk("abort_en",   32'(reg_en), 0);
    chk("abort_busy", 32'(busy), 0);
    any_ack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack != 0) any_ack = 1;
    end
    chk("abort_noack", 32'(any_ack), 0);
    req = 4'b0011;
    tick();
    tick();
    req = '0;
    chk("abort_ptr", 32'(gnt), 32'b0001);
    tick();
    tick();

`ifdef REG_ARB_LOCK_EN
    // Locked requester 0 keeps the grant, requester 1 waits for unlock
    do_reset();
    lock = 4'b0001; req = 4'b0011;
    last = 0; k = 0;
    for (int c = 0; c < 60 && k < 12; c++) begin
      tick();
      if (ack != 0) begin
        if (k > 0 && k < 3) chk("lock_gap", 32'(c - last), 2);
        if (k < 3) chk("lock_win", 32'(idx_of(ack)), 0);
        if (k == 2) lock = '0;
        if (idx_of(ack) == 1) begin
          chk("lock_release", 32'(k >= 3), 1);
          k = 100;
        end else begin
          last = c;
          k++;
        end
      end
    end
    chk("lock_r1_seen", 32'(k == 100), 1);
    req = '0;
    tick(); tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
